// File: rtl/johnson_pkg.sv
// Shared types, legal ring codes and ring helper functions for the Johnson slot arbiter.
package johnson_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

   // Legal 4-bit Johnson codes, indexed by phase (element 0 is phase 0).
   localparam logic [0:7][3:0] JOHNSON_CODES = {
      4'b0000, 4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000
   };

   function automatic logic [3:0] johnson_next(input logic [3:0] q);
      return {q[2:0], ~q[3]};
   endfunction

   function automatic logic [7:0] johnson_decode(input logic [3:0] q);
      logic [7:0] p;
      p[0] = ~q[3] & ~q[0];
      p[1] = ~q[1] &  q[0];
      p[2] = ~q[2] &  q[1];
      p[3] = ~q[3] &  q[2];
      p[4] =  q[3] &  q[0];
      p[5] =  q[1] & ~q[0];
      p[6] =  q[2] & ~q[1];
      p[7] =  q[3] & ~q[2];
      return p;
   endfunction

endpackage

// File: rtl/johnson_ring.sv
// 4-bit Johnson ring register with step enable, sync clear, phase decode and legality flag.
module johnson_ring
   import johnson_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_step,
   input  logic       i_clr,
   output logic [3:0] o_q,
   output logic [7:0] o_onehot,
   output logic       o_legal
);

   logic [3:0] r_q;
   logic       w_legal;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clr)
         r_q <= 4'b0000;
      else if (i_step)
         r_q <= johnson_next(r_q);
   end

   always_comb begin
      w_legal = 1'b0;
      for (int i = 0; i < 8; i++)
         if (r_q == JOHNSON_CODES[i]) w_legal = 1'b1;
   end

   assign o_q      = r_q;
   assign o_onehot = johnson_decode(r_q);
   assign o_legal  = w_legal;

endmodule

// File: rtl/johnson_slot_arbiter.sv
// Eight-way time-slot arbiter: a Johnson ring walks the slots, an FSM grants the slot owner
// for up to MAX_HOLD cycles, and illegal ring codes force a recovery to phase 0 / IDLE.
module johnson_slot_arbiter
   import johnson_pkg::*;
#(
   parameter int MAX_HOLD = 4
)(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [7:0] i_req,
   output logic [7:0] o_gnt,
   output logic       o_gnt_valid,
   output logic [2:0] o_phase,
   output logic [3:0] o_johnson_q,
   output logic       o_illegal_err
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   state_t            r_state;
   logic [7:0]        r_gnt;
   logic              r_gnt_valid;
   logic              r_illegal_err;
   logic [HOLD_W-1:0] r_hold;

   logic [3:0] w_q;
   logic [7:0] w_onehot;
   logic       w_legal;
   logic       w_req_hit;
   logic       w_any_req;
   logic       w_exit;
   logic       w_step;
   logic [2:0] w_phase;

   assign w_req_hit = |(i_req & w_onehot);
   assign w_any_req = |i_req;
   assign w_exit    = !w_req_hit || (r_hold == HOLD_W'(MAX_HOLD));

   // Ring moves only while scanning past empty slots or when a grant finishes.
   assign w_step = ((r_state == SCAN) && !w_req_hit && w_any_req && i_enable) ||
                   ((r_state == GRANT) && w_exit);

   johnson_ring u_ring (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_step   (w_step),
      .i_clr    (!w_legal),
      .o_q      (w_q),
      .o_onehot (w_onehot),
      .o_legal  (w_legal)
   );

   always_comb begin
      w_phase = 3'd0;
      for (int i = 0; i < 8; i++)
         if (w_onehot[i]) w_phase = w_phase | 3'(i);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_gnt         <= '0;
         r_gnt_valid   <= 1'b0;
         r_hold        <= '0;
         r_illegal_err <= 1'b0;
      end else if (!w_legal) begin
         r_state       <= IDLE;
         r_gnt         <= '0;
         r_gnt_valid   <= 1'b0;
         r_hold        <= '0;
         r_illegal_err <= 1'b1;
      end else begin
         r_illegal_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_enable && w_any_req) r_state <= SCAN;
            end
            SCAN: begin
               if (w_req_hit) begin
                  r_state     <= GRANT;
                  r_gnt       <= w_onehot;
                  r_gnt_valid <= 1'b1;
                  r_hold      <= HOLD_W'(1);
               end else if (!w_any_req || !i_enable) begin
                  r_state <= IDLE;
               end
            end
            GRANT: begin
               if (w_exit) begin
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_hold      <= '0;
                  r_state     <= (i_enable && w_any_req) ? SCAN : IDLE;
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_gnt         = r_gnt;
   assign o_gnt_valid   = r_gnt_valid;
   assign o_phase       = w_phase;
   assign o_johnson_q   = w_q;
   assign o_illegal_err = r_illegal_err;

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
// Table-driven bench: per-cycle {inputs, expected outputs} rows plus a hand-written illegal-code sequence.
module tb_johnson_slot_arbiter;

   localparam logic [3:0] P0 = 4'b0000, P1 = 4'b0001, P2 = 4'b0011, P3 = 4'b0111,
                          P4 = 4'b1111, P5 = 4'b1110, P6 = 4'b1100, P7 = 4'b1000;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_enable = 1'b0;
   logic [7:0] i_req = 8'h00;
   logic [7:0] o_gnt;
   logic       o_gnt_valid;
   logic [2:0] o_phase;
   logic [3:0] o_johnson_q;
   logic       o_illegal_err;

   johnson_slot_arbiter #(.MAX_HOLD(4)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_enable      (i_enable),
      .i_req         (i_req),
      .o_gnt         (o_gnt),
      .o_gnt_valid   (o_gnt_valid),
      .o_phase       (o_phase),
      .o_johnson_q   (o_johnson_q),
      .o_illegal_err (o_illegal_err)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [3:0] q;
   } vec_t;

   vec_t vecs[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic add(input logic r, input logic e, input logic [7:0] rq,
                      input logic [7:0] g, input logic [3:0] q);
      vec_t v;
      v.rst = r; v.en = e; v.req = rq; v.gnt = g; v.q = q;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
   endtask

   function automatic logic [2:0] phase_of(input logic [3:0] q);
      logic [3:0] codes [8];
      codes = '{P0, P1, P2, P3, P4, P5, P6, P7};
      phase_of = 3'd0;
      for (int i = 0; i < 8; i++)
         if (codes[i] == q) phase_of = 3'(i);
   endfunction

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic check_row(input string tag, input int row, input logic [7:0] g, input logic [3:0] q,
                            input logic err);
      chk({tag, "_gnt"}, row, o_gnt, g);
      chk({tag, "_gnt_valid"}, row, {7'd0, o_gnt_valid}, {7'd0, |g});
      chk({tag, "_johnson_q"}, row, {4'd0, o_johnson_q}, {4'd0, q});
      chk({tag, "_phase"}, row, {5'd0, o_phase}, {5'd0, phase_of(q)});
      chk({tag, "_illegal_err"}, row, {7'd0, o_illegal_err}, {7'd0, err});
   endtask

   initial begin
      logic [3:0] seq [8];
      seq = '{P0, P1, P2, P3, P4, P5, P6, P7};

      // single requester 0: grant two cycles after enable, held 4 cycles, ring then at phase 1
      add(1,0,8'h00,8'h00,P0); add(1,0,8'h00,8'h00,P0);
      add(0,1,8'h01,8'h00,P0);
      repeat (4) add(0,1,8'h01,8'h01,P0);
      add(0,1,8'h01,8'h00,P1); add(0,1,8'h00,8'h00,P1);

      // requester 7 from phase 0: 7 scan steps then grant
      add(1,0,8'h00,8'h00,P0);
      add(0,1,8'h80,8'h00,P0);
      for (int k = 1; k < 8; k++) add(0,1,8'h80,8'h00,seq[k]);
      repeat (4) add(0,1,8'h80,8'h80,P7);
      add(0,1,8'h80,8'h00,P0); add(0,1,8'h00,8'h00,P0);

      // requesters 0 and 4 steady: alternate 01,10,01 with 4-cycle grants
      add(0,1,8'h11,8'h00,P0);
      repeat (4) add(0,1,8'h11,8'h01,P0);
      add(0,1,8'h11,8'h00,P1); add(0,1,8'h11,8'h00,P2);
      add(0,1,8'h11,8'h00,P3); add(0,1,8'h11,8'h00,P4);
      repeat (4) add(0,1,8'h11,8'h10,P4);
      add(0,1,8'h11,8'h00,P5); add(0,1,8'h11,8'h00,P6);
      add(0,1,8'h11,8'h00,P7); add(0,1,8'h11,8'h00,P0);
      repeat (4) add(0,1,8'h11,8'h01,P0);
      add(0,1,8'h11,8'h00,P1); add(0,1,8'h00,8'h00,P1);

      // requester 2 drops after 2 grant cycles
      add(0,1,8'h04,8'h00,P1); add(0,1,8'h04,8'h00,P2);
      add(0,1,8'h04,8'h04,P2); add(0,1,8'h04,8'h04,P2);
      add(0,1,8'h00,8'h00,P3); add(0,1,8'h00,8'h00,P3);

      // enable dropped mid-grant: grant runs its full length, then IDLE
      add(0,1,8'h08,8'h00,P3); add(0,1,8'h08,8'h08,P3);
      repeat (3) add(0,0,8'h08,8'h08,P3);
      add(0,0,8'h08,8'h00,P4); add(0,0,8'h08,8'h00,P4);

      // reset asserted mid-grant
      add(0,1,8'h10,8'h00,P4); add(0,1,8'h10,8'h10,P4); add(0,1,8'h10,8'h10,P4);
      add(1,1,8'h10,8'h00,P0); add(0,0,8'h00,8'h00,P0);

      foreach (vecs[r]) begin
         i_reset = vecs[r].rst; i_enable = vecs[r].en; i_req = vecs[r].req;
         tick();
         check_row("vec", r, vecs[r].gnt, vecs[r].q, 1'b0);
      end

      // illegal ring code injected during a grant
      i_reset = 1'b1; i_enable = 1'b0; i_req = 8'h00; tick();
      i_reset = 1'b0; i_enable = 1'b1; i_req = 8'h01; tick();
      tick();
      check_row("ill_pre", 0, 8'h01, P0, 1'b0);
      @(negedge i_clock);
      force dut.u_ring.r_q = 4'b0101;
      #1 release dut.u_ring.r_q;
      tick();
      check_row("ill_hit", 1, 8'h00, P0, 1'b1);
      tick();
      check_row("ill_idle", 2, 8'h00, P0, 1'b0);
      tick();
      check_row("ill_regrant", 3, 8'h01, P0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
